nios2mypio_pio_out: RTL
=======================

# nios2mypio_pio_out

Avalon-MM slave output PIO driving a 4-bit `out_port` from the Nios II data bus. It is the write-side counterpart of the system's input PIO: same register-map style, same 1-cycle registered read latency. It adds atomic set/clear registers and a self-timed pulse generator, so firmware can emit fixed-width strobes without busy-waiting. It sits in the Qsys system between the CPU data master and board-level outputs (LEDs, strobes).

## Interface
Parameters:
- `DATA_WIDTH`, 4: width of `out_port` and all data/mask fields.
- `RESET_VALUE`, 4'h0: value loaded into the DATA register on reset.
- `LEN_WIDTH`, 16: width of the pulse-length register and down-counter.

Ports:
- `clk`  in  1  system clock. One clock: everything is synchronous to it.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `address`  in  3  register word address.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe. A write occurs when `chipselect`=1 and `write_n`=0.
- `writedata`  in  32  write data. Only the low bits are used.
- `readdata`  out  32  registered read data.
- `out_port`  out  DATA_WIDTH  output pins.

## Operation
Register map (word addresses):
- 0 DATA (RW): `data_reg`. Reads return `data_reg`, not `out_port`.
- 1 PULSE_LEN (RW): `len_reg` = writedata[LEN_WIDTH-1:0].
- 2 PULSE (W/R):
  - Write: loads `pulse_mask` = writedata[DATA_WIDTH-1:0] and `count` = `len_reg`, then starts a pulse.
  - Read: bit31 = busy, bits[DATA_WIDTH-1:0] = `pulse_mask`, all other bits 0.
- 4 OUTSET (W): `data_reg` |= writedata[DATA_WIDTH-1:0]. Reads return 0.
- 5 OUTCLEAR (W): `data_reg` &= ~writedata[DATA_WIDTH-1:0]. Reads return 0.
- 3, 6, 7: reads return 0; writes are ignored.

Output:
- `out_port` = `data_reg` | (busy ? `pulse_mask` : 0).
- It is driven combinationally from registers only; there is no input-to-output combinational path.

Pulse FSM, states IDLE and ACTIVE:
- IDLE → ACTIVE: PULSE write with `len_reg` != 0 and mask != 0.
- PULSE write with `len_reg` = 0 or mask = 0: stay IDLE and leave `pulse_mask` = 0.
- ACTIVE: `count` decrements each cycle. When `count` = 1 the next edge goes to IDLE and clears `pulse_mask`.
- PULSE write while ACTIVE retriggers: the new mask and `len_reg` are reloaded. Retrigger beats expiry on the same edge.
- Writing PULSE_LEN while ACTIVE does not alter the running `count`.
- busy = (state == ACTIVE).

Bit handling:
- writedata bits above the field width are ignored.
- Unused `readdata` bits are 0.

## Timing
- Reset values: `readdata`=0, `out_port`=RESET_VALUE, `data_reg`=RESET_VALUE, `len_reg`=0, `pulse_mask`=0, `count`=0, state IDLE.
- Write sampled at edge k: the register updates at edge k and `out_port` shows the new value after edge k.
- Pulse started at edge k: the pulse bits are high for exactly `len_reg` cycles, edges k..k+L, and low after edge k+L.
- Read: `readdata` is registered every cycle from `address`, independent of `chipselect`. Read latency is 1 cycle.
- A read of the same address in the cycle after a write returns the updated value.
- Counter never wraps. The ACTIVE exit happens at `count`=1, so `count` never underflows.
- Reset asserted mid-pulse: all outputs go to their reset values immediately and asynchronously. The FSM resumes in IDLE after reset release.

## Configuration
- Macro `NIOS2MYPIO_PIO_OUT_PULSE_EN`.
- Defined: the PULSE_LEN/PULSE registers and the FSM are compiled in, as described above.
- Undefined:
  - Addresses 1 and 2 behave as reserved (read 0, writes ignored).
  - `out_port` = `data_reg`.
  - The FSM, counter and `len_reg` are absent.

## Test plan
- Reset: assert `reset_n`=0 mid-cycle → `out_port`=4'h0, `readdata`=0 asynchronously. Read address 0 after release → 0.
- DATA write 32'hFFFF_FFF5 → `out_port`=4'h5 next cycle. Read address 0 → `readdata`=32'h5 one cycle later.
- OUTSET 4'hA after DATA=4'h5 → 4'hF. Then OUTCLEAR 4'h3 → 4'hC. Reads of addresses 4 and 5 → 0.
- PULSE_LEN=3, DATA=0, PULSE mask=4'h2 → `out_port`=4'h2 for exactly 3 cycles, then 0. PULSE read shows bit31=1 during the pulse and 0 after.
- Retrigger: PULSE_LEN=5, start the pulse, write PULSE mask=4'h8 at cycle 3 → bit3 high for 5 cycles from the retrigger. Then PULSE_LEN=0 with a PULSE write → no pulse, busy=0.
- Macro undefined build: write addresses 1 and 2 → no `out_port` change, reads return 0.

Source files
------------

// File: rtl/nios2mypio_pio_out.sv
// Avalon-MM output PIO with set/clear and self-timed pulse (pulse logic under NIOS2MYPIO_PIO_OUT_PULSE_EN).
// Writes take effect at the sampling edge, readdata is registered (1-cycle latency), no wait states or backpressure.
module nios2mypio_pio_out #(
  parameter int                    DATA_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA  = 3'd0;
  localparam logic [2:0] A_SET   = 3'd4;
  localparam logic [2:0] A_CLEAR = 3'd5;

  logic                  wr;
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [31:0]           rd_next;
  logic                  unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wmask        = writedata[DATA_WIDTH-1:0];
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        A_DATA:  data_reg <= wmask;
        A_SET:   data_reg <= data_reg | wmask;
        A_CLEAR: data_reg <= data_reg & ~wmask;
        default: ;
      endcase
    end
  end

`ifdef NIOS2MYPIO_PIO_OUT_PULSE_EN
  localparam logic [2:0] A_LEN   = 3'd1;
  localparam logic [2:0] A_PULSE = 3'd2;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  count;
  logic [DATA_WIDTH-1:0] pulse_mask;
  logic                  busy;

  assign busy = (state == ACTIVE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_reg <= '0;
    end else if (wr && address == A_LEN) begin
      len_reg <= writedata[LEN_WIDTH-1:0];
    end
  end

  // A PULSE write is checked first so a retrigger wins over expiry on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      pulse_mask <= '0;
    end else if (wr && address == A_PULSE) begin
      if (len_reg != '0 && wmask != '0) begin
        state      <= ACTIVE;
        count      <= len_reg;
        pulse_mask <= wmask;
      end else begin
        state      <= IDLE;
        count      <= '0;
        pulse_mask <= '0;
      end
    end else if (state == ACTIVE) begin
      count <= count - LEN_WIDTH'(1);
      if (count == LEN_WIDTH'(1)) begin
        state      <= IDLE;
        pulse_mask <= '0;
      end
    end
  end

  assign out_port = data_reg | (busy ? pulse_mask : '0);
`else
  assign out_port = data_reg;
`endif

  always_comb begin
    rd_next = '0;
    case (address)
      A_DATA:  rd_next[DATA_WIDTH-1:0] = data_reg;
`ifdef NIOS2MYPIO_PIO_OUT_PULSE_EN
      A_LEN:   rd_next[LEN_WIDTH-1:0] = len_reg;
      A_PULSE: begin
        rd_next[31]             = busy;
        rd_next[DATA_WIDTH-1:0] = pulse_mask;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule
